// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, frame width, default oversampling.
// Consumers may enable 2-of-3 sample voting with the RX_MAJORITY_EN macro.
package uart_pkg;

   localparam int DATA_BITS      = 8;
   localparam int OVERSAMPLE_DEF = 16;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t ST_IDLE  = 3'd0;
   localparam rx_state_t ST_START = 3'd1;
   localparam rx_state_t ST_DATA  = 3'd2;
   localparam rx_state_t ST_STOP  = 3'd3;
   localparam rx_state_t ST_BREAK = 3'd4;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
   input  logic rx_clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge rx_clk) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rx_core.sv
// Oversampled UART receiver (8N1) with a single-entry holding register and overrun/framing pulses.
// Build option: define RX_MAJORITY_EN for 2-of-3 voting around every sample point.
module rx_core
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                 rx_clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   output logic                 rx_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
   localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 line;
   logic                 bit_val;
   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [2:0]           idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 stop_hit;
   logic                 good;
   logic                 bad;

   uart_sync u_sync (
      .rx_clk (rx_clk),
      .reset  (reset),
      .d      (rx),
      .q      (rx_s)
   );

`ifdef RX_MAJORITY_EN
   // The FSM runs one cycle behind rx_s so that the cycle after each sample
   // point is already visible when the counter reaches it.
   logic [1:0] hist;

   always_ff @(posedge rx_clk) begin
      if (reset) hist <= 2'b11;
      else       hist <= {hist[0], rx_s};
   end

   assign line    = hist[0];
   assign bit_val = maj3(hist[1], hist[0], rx_s);
`else
   assign line    = rx_s;
   assign bit_val = rx_s;
`endif

   always_ff @(posedge rx_clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (!line) state <= ST_START;
            end
            ST_START: begin
               if (cnt == HALF_M1) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= bit_val ? ST_IDLE : ST_DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DATA: begin
               if (cnt == FULL_M1) begin
                  cnt        <= '0;
                  shreg[idx] <= bit_val;
                  if (idx == LAST_IDX) state <= ST_STOP;
                  else                 idx   <= idx + 3'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_STOP: begin
               if (cnt == FULL_M1) begin
                  cnt   <= '0;
                  state <= bit_val ? ST_IDLE : ST_BREAK;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_BREAK: begin
               cnt <= '0;
               if (line) state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign stop_hit = (state == ST_STOP) && (cnt == FULL_M1);
   assign good     = stop_hit &&  bit_val;
   assign bad      = stop_hit && !bit_val;

   // A simultaneous accept frees the holding register in time for the new byte.
   always_ff @(posedge rx_clk) begin
      if (reset) begin
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         rx_frame_err <= bad;
         rx_overrun   <= good && rx_valid && !rx_ready;
         if (good && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_rx_core.sv
// Directed bench for rx_core: table of whole frames plus hand sequences for glitch, overrun, reset, voting.
module tb_rx_core;

   localparam int OS = 16;
   localparam int FRAME_CYC = 10 * OS;

   logic       rx_clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_busy;

   always #5 rx_clk = ~rx_clk;

   rx_core #(.OVERSAMPLE(OS)) dut (
      .rx_clk       (rx_clk),
      .reset        (reset),
      .rx           (rx),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun),
      .rx_busy      (rx_busy)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   int         valid_cyc = 0;
   int         ferr_cnt = 0;
   int         ovr_cnt = 0;
   logic [7:0] last_acc = 8'h00;

   always @(negedge rx_clk) begin
      valid_cyc <= valid_cyc + int'(rx_valid);
      ferr_cnt  <= ferr_cnt + int'(rx_frame_err);
      ovr_cnt   <= ovr_cnt + int'(rx_overrun);
      if (rx_valid && rx_ready) last_acc <= rx_data;
   end

   task automatic tick();
      @(negedge rx_clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One 8N1 frame; glitch >= 0 inverts the line for that single cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch);
      for (int c = 0; c < FRAME_CYC; c++) begin
         int   bi;
         logic v;
         bi = c / OS;
         if (bi == 0)      v = 1'b0;
         else if (bi <= 8) v = b[bi-1];
         else              v = stop;
         rx = v ^ (c == glitch);
         tick();
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_data;
      int         exp_valid;
      int         exp_ferr;
   } vec_t;

   vec_t vt[7];

   initial begin
      int v0, f0, o0;
      logic [7:0] maj_exp;

      vt[0] = '{8'h55, 1'b1, 8'h55, 1, 0};
      vt[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
      vt[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
      vt[3] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
      vt[4] = '{8'h80, 1'b1, 8'h80, 1, 0};
      vt[5] = '{8'h01, 1'b1, 8'h01, 1, 0};
      vt[6] = '{8'hA3, 1'b0, 8'h00, 0, 1};

      reset    = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b1;
      repeat (3) tick();
      chk("rst_data",  int'(rx_data), 0);
      chk("rst_valid", int'(rx_valid), 0);
      chk("rst_ferr",  int'(rx_frame_err), 0);
      chk("rst_ovr",   int'(rx_overrun), 0);
      chk("rst_busy",  int'(rx_busy), 0);
      reset = 1'b0;
      repeat (5) tick();

      foreach (vt[i]) begin
         v0 = valid_cyc; f0 = ferr_cnt; o0 = ovr_cnt;
         send_frame(vt[i].data, vt[i].stop, -1);
         if (!vt[i].stop) begin
            rx = 1'b0;
            repeat (100) tick();
            chk($sformatf("vec%0d_break_busy", i), int'(rx_busy), 1);
            rx = 1'b1;
            repeat (10) tick();
         end else begin
            rx = 1'b1;
            repeat (24) tick();
            chk($sformatf("vec%0d_data", i), int'(last_acc), int'(vt[i].exp_data));
         end
         chk($sformatf("vec%0d_valid_cycles", i), valid_cyc - v0, vt[i].exp_valid);
         chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vt[i].exp_ferr);
         chk($sformatf("vec%0d_ovr", i), ovr_cnt - o0, 0);
         chk($sformatf("vec%0d_idle", i), int'(rx_busy), 0);
      end

      // Short low pulse is a false start.
      v0 = valid_cyc; f0 = ferr_cnt;
      rx = 1'b0;
      repeat (4) tick();
      rx = 1'b1;
      repeat (2) tick();
      chk("glitch_busy", int'(rx_busy), 1);
      repeat (30) tick();
      chk("glitch_idle",  int'(rx_busy), 0);
      chk("glitch_valid", valid_cyc - v0, 0);
      chk("glitch_ferr",  ferr_cnt - f0, 0);

      // Back-to-back bytes with a stalled consumer.
      rx_ready = 1'b0;
      o0 = ovr_cnt; f0 = ferr_cnt;
      send_frame(8'h12, 1'b1, -1);
      send_frame(8'h34, 1'b1, -1);
      rx = 1'b1;
      repeat (24) tick();
      chk("ovr_data",  int'(rx_data), 'h12);
      chk("ovr_valid", int'(rx_valid), 1);
      chk("ovr_pulse", ovr_cnt - o0, 1);
      chk("ovr_ferr",  ferr_cnt - f0, 0);
      rx_ready = 1'b1;
      tick();
      chk("ovr_clear", int'(rx_valid), 0);
      chk("ovr_hold",  int'(rx_data), 'h12);

      // Reset in the middle of 0xFF data bits.
      v0 = valid_cyc; f0 = ferr_cnt; o0 = ovr_cnt;
      for (int c = 0; c < 4 * OS; c++) begin
         rx = (c < OS) ? 1'b0 : 1'b1;
         tick();
      end
      chk("mid_busy", int'(rx_busy), 1);
      reset = 1'b1;
      tick();
      chk("mid_rst_busy",  int'(rx_busy), 0);
      chk("mid_rst_data",  int'(rx_data), 0);
      chk("mid_rst_valid", int'(rx_valid), 0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (30) tick();
      chk("mid_no_valid", valid_cyc - v0, 0);
      chk("mid_no_ferr",  ferr_cnt - f0, 0);
      chk("mid_no_ovr",   ovr_cnt - o0, 0);
      chk("mid_idle",     int'(rx_busy), 0);
      send_frame(8'h0F, 1'b1, -1);
      rx = 1'b1;
      repeat (24) tick();
      chk("post_rst_data",  int'(last_acc), 'h0F);
      chk("post_rst_valid", valid_cyc - v0, 1);

      // Inverted single cycle at the centre of bit 3 of 0x00.
`ifdef RX_MAJORITY_EN
      maj_exp = 8'h00;
`else
      maj_exp = 8'h08;
`endif
      v0 = valid_cyc;
      send_frame(8'h00, 1'b1, 4 * OS + OS / 2);
      rx = 1'b1;
      repeat (24) tick();
      chk("vote_data",  int'(last_acc), int'(maj_exp));
      chk("vote_valid", valid_cyc - v0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rx_core.md
RX_CORE -- requirements
Module: rx_core

Interface
REQ-001 Parameter OVERSAMPLE, default 16: rx_clk cycles per bit; SHALL be an even value of at least 4.
REQ-002 rx_clk  input  1  sole clock, OVERSAMPLE x baud rate; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx  input  1  asynchronous serial line; idle high; frame = start(0), 8 data bits LSB first, stop(1).
REQ-005 rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-006 rx_data  output  8  received byte, stable while rx_valid high.
REQ-007 rx_valid  output  1  byte available; held until accepted.
REQ-008 rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 rx_overrun  output  1  one-cycle pulse: good byte dropped because the holding register was full.
REQ-010 rx_busy  output  1  high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; 2 cycles of latency.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: rx_s==0 -> START, with the sample counter cleared.
REQ-014 START: at counter == OVERSAMPLE/2-1 (mid-bit), sample; 1 -> IDLE (glitch rejected, no outputs); 0 -> DATA, counter cleared, bit index 0.
REQ-015 DATA: at every counter == OVERSAMPLE-1, sample and shift into bit[index]; after index 7 -> STOP.
REQ-016 STOP: at counter == OVERSAMPLE-1, sample; 1 -> good byte, IDLE; 0 -> rx_frame_err pulse, byte discarded, BREAK.
REQ-017 BREAK: remain until rx_s==1, then -> IDLE; a line held low SHALL NOT produce repeated frames or errors.
REQ-018 Good byte with rx_valid==0, or with rx_valid&rx_ready in the same cycle: load rx_data and set rx_valid on the next edge.
REQ-019 Good byte with rx_valid==1 and rx_ready==0: pulse rx_overrun; rx_data and rx_valid unchanged; new byte dropped.
REQ-020 rx_valid&rx_ready with no simultaneous load: rx_valid clears on the next edge; rx_data holds its last value.
REQ-021 Counter width SHALL be $clog2(OVERSAMPLE); the bit index is 3 bits; neither wraps outside its state.

Reset
REQ-022 Reset SHALL force IDLE, synchronizer flops 1, counters 0, rx_data 0x00, and rx_valid, rx_frame_err, rx_overrun, rx_busy to 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame without any output pulse; reception resumes on the next falling edge after reset deasserts.

Configuration
REQ-024 Macro RX_MAJORITY_EN defined: each sample point (start, data, stop) is the 2-of-3 majority of rx_s at point-1, point and point+1, with the decision taken at point+1.
REQ-025 RX_MAJORITY_EN undefined: single sample of rx_s at the point; no voting logic.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state typedef, the DATA_BITS=8 constant and the default OVERSAMPLE.
REQ-027 The 2-flop synchronizer SHALL be sub-module uart_sync; all other logic lives in rx_core.

Verification
REQ-028 OVERSAMPLE=16, frame 0x55 sent, rx_ready=1 -> rx_data=0x55, rx_valid for 1 cycle, no error pulses.
REQ-029 rx low for 4 cycles then high -> FSM returns to IDLE, no rx_valid, no rx_frame_err.
REQ-030 Frame 0xA3 with stop bit 0, then line low 100 cycles -> one rx_frame_err pulse, FSM stays in BREAK, no rx_valid; line high -> IDLE.
REQ-031 Bytes 0x12 then 0x34 back-to-back, rx_ready=0 -> rx_data stays 0x12, one rx_overrun pulse; rx_ready=1 -> rx_valid clears.
REQ-032 Reset asserted mid-data on 0xFF -> all outputs 0, FSM IDLE; next frame 0x0F received correctly.
REQ-033 RX_MAJORITY_EN defined, single-cycle inverted glitch at the mid-bit of bit 3 in 0x00 -> rx_data=0x00; macro undefined -> rx_data=0x08.
